// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the 68000 bus-cycle controller.
package bus_cycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_FAULT,
        ST_AVEC,
        ST_DONE
    } state_t;

    localparam logic [2:0] FC_INT_ACK  = 3'b111;
    localparam logic [3:0] AVEC_NIBBLE = 4'hF;

    // Width of a region index; never zero so a single-region build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_cycle_controller_region_decoder.sv
// Combinational priority match of an address against the chip-select windows.
module region_decoder
    import bus_cycle_pkg::*;
#(
    parameter int REGIONS    = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int WAIT_WIDTH = 4,
    parameter int IDX_WIDTH  = idx_width(REGIONS)
) (
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [REGIONS*ADDR_WIDTH-1:0] base,
    input  logic [REGIONS*ADDR_WIDTH-1:0] mask,
    input  logic [REGIONS*WAIT_WIDTH-1:0] wait_all,
    input  logic [REGIONS-1:0]            writable_all,
    output logic                          hit,
    output logic [IDX_WIDTH-1:0]          idx,
    output logic [WAIT_WIDTH-1:0]         wait_states,
    output logic                          writable
);

    always_comb begin
        hit         = 1'b0;
        idx         = '0;
        wait_states = '0;
        writable    = 1'b0;
        // First match in ascending order wins; later matches are ignored.
        for (int unsigned i = 0; i < REGIONS; i++) begin
            if (!hit && (((addr ^ base[i*ADDR_WIDTH +: ADDR_WIDTH])
                          & mask[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0)) begin
                hit         = 1'b1;
                idx         = IDX_WIDTH'(i);
                wait_states = wait_all[i*WAIT_WIDTH +: WAIT_WIDTH];
                writable    = writable_all[i];
            end
        end
    end

endmodule

// File: rtl/bus_cycle_controller.sv
// 68000 asynchronous bus-cycle controller: strobe synchronisation, chip-select
// decode with per-region wait states, and data / bus-error / autovector termination.
module bus_cycle_controller
    import bus_cycle_pkg::*;
#(
    parameter int REGIONS        = 4,
    parameter int ADDR_WIDTH     = 24,
    parameter int WAIT_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          MCLK_IN,
    input  logic                          RESET_ALL_IN,
    input  logic                          AS_IN,
    input  logic                          UDS_IN,
    input  logic                          LDS_IN,
    input  logic                          WR_IN,
    input  logic [2:0]                    MPU_STATUS_CODE_IN,
    input  logic [ADDR_WIDTH-1:0]         ADDR_IN,
    input  logic [REGIONS*ADDR_WIDTH-1:0] REGION_BASE_IN,
    input  logic [REGIONS*ADDR_WIDTH-1:0] REGION_MASK_IN,
    input  logic [REGIONS*WAIT_WIDTH-1:0] REGION_WAIT_IN,
    input  logic [REGIONS-1:0]            REGION_WRITABLE_IN,
    output logic [REGIONS-1:0]            CS,
    output logic                          OUTPUT_ENABLE,
    output logic                          DATA_ACK,
    output logic                          BUS_ERROR_ACK,
    output logic                          INT_AUTOVEC_ACK,
    output logic                          CYCLE_ACTIVE
);

    localparam int IDX_W = idx_width(REGIONS);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    logic as_meta, uds_meta, lds_meta, wr_meta;
    logic as_s, uds_s, lds_s, wr_s;
    logic ds_s;
    logic as_prev;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              fc_q;
    logic                    wr_q;
    logic                    capture;
    logic [WAIT_WIDTH-1:0]   wcnt, wcnt_n;
    logic [TO_W-1:0]         tcnt, tcnt_n;
    logic [IDX_W-1:0]        sel_q, sel_n;

    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic [WAIT_WIDTH-1:0]   hit_wait;
    logic                    hit_writable;

    logic [REGIONS-1:0]      cs_n;
    logic                    oe_n, dack_n, berr_n, avec_n, active_n;

    always_ff @(posedge MCLK_IN) begin
        as_meta  <= AS_IN;
        uds_meta <= UDS_IN;
        lds_meta <= LDS_IN;
        wr_meta  <= WR_IN;
        as_s     <= as_meta;
        uds_s    <= uds_meta;
        lds_s    <= lds_meta;
        wr_s     <= wr_meta;
    end

    assign ds_s = uds_s | lds_s;

    region_decoder #(
        .REGIONS    (REGIONS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WAIT_WIDTH (WAIT_WIDTH),
        .IDX_WIDTH  (IDX_W)
    ) u_region_decoder (
        .addr         (addr_q),
        .base         (REGION_BASE_IN),
        .mask         (REGION_MASK_IN),
        .wait_all     (REGION_WAIT_IN),
        .writable_all (REGION_WRITABLE_IN),
        .hit          (hit),
        .idx          (hit_idx),
        .wait_states  (hit_wait),
        .writable     (hit_writable)
    );

    // as_prev resets high so an AS_S still asserted across reset is not taken as a new cycle.
    always_ff @(posedge MCLK_IN) begin
        if (RESET_ALL_IN) begin
            state           <= ST_IDLE;
            as_prev         <= 1'b1;
            wcnt            <= '0;
            tcnt            <= '0;
            sel_q           <= '0;
            addr_q          <= '0;
            fc_q            <= '0;
            wr_q            <= 1'b0;
            CS              <= '0;
            OUTPUT_ENABLE   <= 1'b0;
            DATA_ACK        <= 1'b0;
            BUS_ERROR_ACK   <= 1'b0;
            INT_AUTOVEC_ACK <= 1'b0;
            CYCLE_ACTIVE    <= 1'b0;
        end else begin
            state           <= state_n;
            as_prev         <= as_s;
            wcnt            <= wcnt_n;
            tcnt            <= tcnt_n;
            sel_q           <= sel_n;
            if (capture) begin
                addr_q <= ADDR_IN;
                fc_q   <= MPU_STATUS_CODE_IN;
                wr_q   <= wr_s;
            end
            CS              <= cs_n;
            OUTPUT_ENABLE   <= oe_n;
            DATA_ACK        <= dack_n;
            BUS_ERROR_ACK   <= berr_n;
            INT_AUTOVEC_ACK <= avec_n;
            CYCLE_ACTIVE    <= active_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        tcnt_n  = tcnt;
        sel_n   = sel_q;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (as_s && !as_prev) begin
                    state_n = ST_DECODE;
                    capture = 1'b1;
                    tcnt_n  = '0;
                end
            end
            ST_DECODE: begin
                if (!as_s) begin
                    state_n = ST_DONE;
                end else if (ds_s) begin
                    if (fc_q == FC_INT_ACK && addr_q[19:16] == AVEC_NIBBLE) begin
                        state_n = ST_AVEC;
                    end else if (!hit || (wr_q && !hit_writable)) begin
                        state_n = ST_FAULT;
                    end else begin
                        state_n = ST_WAIT;
                        wcnt_n  = hit_wait;
                        sel_n   = hit_idx;
                    end
                end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n = ST_FAULT;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!as_s) begin
                    state_n = ST_DONE;
                end else if (wcnt == '0) begin
                    state_n = ST_ACK;
                end else begin
                    wcnt_n = wcnt - 1'b1;
                end
            end
            ST_ACK, ST_FAULT, ST_AVEC: begin
                if (!as_s) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the transition edge.
    always_comb begin
        cs_n     = '0;
        oe_n     = 1'b0;
        dack_n   = 1'b0;
        berr_n   = 1'b0;
        avec_n   = 1'b0;
        active_n = 1'b0;
        case (state_n)
            ST_DECODE: active_n = 1'b1;
            ST_WAIT: begin
                cs_n[sel_n] = 1'b1;
                oe_n        = ~wr_q;
                active_n    = 1'b1;
            end
            ST_ACK: begin
                cs_n[sel_n] = 1'b1;
                oe_n        = ~wr_q;
                dack_n      = 1'b1;
                active_n    = 1'b1;
            end
            ST_FAULT: begin
                berr_n   = 1'b1;
                active_n = 1'b1;
            end
            ST_AVEC: begin
                avec_n   = 1'b1;
                active_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed table-driven bench for bus_cycle_controller plus multi-cycle corner sequences.
module tb_bus_cycle_controller;

    localparam int R  = 4;
    localparam int AW = 24;
    localparam int WW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          as_i, uds_i, lds_i, wr_i;
    logic [2:0]    fc_i;
    logic [AW-1:0] addr_i;
    logic [R*AW-1:0] base_i, mask_i;
    logic [R*WW-1:0] wait_i;
    logic [R-1:0]  writable_i;
    logic [R-1:0]  cs;
    logic          oe, dack, berr, avec, active;

    bus_cycle_controller #(
        .REGIONS        (R),
        .ADDR_WIDTH     (AW),
        .WAIT_WIDTH     (WW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .MCLK_IN            (clk),
        .RESET_ALL_IN       (rst),
        .AS_IN              (as_i),
        .UDS_IN             (uds_i),
        .LDS_IN             (lds_i),
        .WR_IN              (wr_i),
        .MPU_STATUS_CODE_IN (fc_i),
        .ADDR_IN            (addr_i),
        .REGION_BASE_IN     (base_i),
        .REGION_MASK_IN     (mask_i),
        .REGION_WAIT_IN     (wait_i),
        .REGION_WRITABLE_IN (writable_i),
        .CS                 (cs),
        .OUTPUT_ENABLE      (oe),
        .DATA_ACK           (dack),
        .BUS_ERROR_ACK      (berr),
        .INT_AUTOVEC_ACK    (avec),
        .CYCLE_ACTIVE       (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    fc;
        logic          wr;
        logic [R-1:0]  cs;
        logic          oe;
        logic          dack;
        logic          berr;
        logic          avec;
        int            lat;   // edge of termination, counted from AS assertion
    } vec_t;

    vec_t vecs[8];
    int passed = 0;
    int total  = 0;

    function automatic logic [8:0] pk(input logic [3:0] c, input logic o, input logic d,
                                      input logic b, input logic a, input logic act);
        return {c, o, d, b, a, act};
    endfunction

    function automatic logic [8:0] outs();
        return {cs, oe, dack, berr, avec, active};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got cs/oe/dack/berr/avec/active=%b expected %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [8:0] exp;
        exp = pk(v.cs, v.oe, v.dack, v.berr, v.avec, 1'b1);
        addr_i = v.addr; fc_i = v.fc; wr_i = v.wr; as_i = 1'b1; lds_i = 1'b1;
        for (int e = 1; e <= v.lat; e++) begin
            step();
            if (e == 3) check($sformatf("v%0d_decode", n), outs(), pk(4'b0, 0, 0, 0, 0, 1));
            if (e == v.lat - 1 && v.lat > 4)
                check($sformatf("v%0d_wait", n), outs(), pk(v.cs, v.oe, 0, 0, 0, 1));
        end
        check($sformatf("v%0d_term", n), outs(), exp);
        as_i = 1'b0; lds_i = 1'b0;
        step(); step();
        check($sformatf("v%0d_hold", n), outs(), exp);
        step();
        check($sformatf("v%0d_release", n), outs(), 9'b0);
        step(); step();
    endtask

    initial begin
        rst = 1'b1; as_i = 0; uds_i = 0; lds_i = 0; wr_i = 0; fc_i = 3'd5; addr_i = '0;
        base_i     = {24'h200000, 24'h000000, 24'h100000, 24'h000000};
        mask_i     = {24'hF00000, 24'hFFFF00, 24'hF00000, 24'hF00000};
        wait_i     = {4'd0, 4'd0, 4'd3, 4'd1};
        writable_i = 4'b1110;

        vecs[0] = '{24'h123456, 3'd5, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 8};
        vecs[1] = '{24'h000100, 3'd5, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[2] = '{24'hE00000, 3'd5, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[3] = '{24'h000010, 3'd5, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 6};
        vecs[4] = '{24'h000010, 3'd1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[5] = '{24'hFFFFF5, 3'd7, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        vecs[6] = '{24'h2ABCDE, 3'd1, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 5};
        vecs[7] = '{24'h1E0000, 3'd7, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 8};

        @(negedge clk);
        step(); step(); step();
        check("reset", outs(), 9'b0);
        rst = 1'b0;
        step(); step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Strobe timeout: AS without any data strobe.
        addr_i = 24'h100000; fc_i = 3'd5; wr_i = 1'b0; as_i = 1'b1;
        for (int e = 1; e <= 3 + TO - 1; e++) step();
        check("timeout_pre", outs(), pk(4'b0, 0, 0, 0, 0, 1));
        step();
        check("timeout_fault", outs(), pk(4'b0, 0, 0, 1, 0, 1));
        as_i = 1'b0;
        step(); step(); step();
        check("timeout_release", outs(), 9'b0);
        step(); step();

        // Abort in WAIT: region 1 via UDS, AS dropped after CS appears.
        addr_i = 24'h1000AA; uds_i = 1'b1; as_i = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        check("abort_cs", outs(), pk(4'b0010, 1, 0, 0, 0, 1));
        as_i = 1'b0; uds_i = 1'b0;
        step(); step(); step();
        check("abort_done", outs(), 9'b0);
        step();
        check("abort_no_ack", outs(), 9'b0);
        step(); step();
        check("abort_idle", outs(), 9'b0);

        // Reset during WAIT with AS held: no new cycle until AS is negated.
        addr_i = 24'h100000; lds_i = 1'b1; as_i = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        check("rst_wait_cs", outs(), pk(4'b0010, 1, 0, 0, 0, 1));
        rst = 1'b1;
        step();
        check("rst_mid", outs(), 9'b0);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        check("rst_no_restart", outs(), 9'b0);
        as_i = 1'b0; lds_i = 1'b0;
        step(); step(); step(); step();
        run_vec(vecs[6], 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
